// File: rtl/monitor_initiator.sv
// monitor_initiator: drives the 3-byte monitor header through a uart, checks echoes, then runs LOAD/DUMP/EXEC payload
module monitor_initiator #(
  parameter int TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  cmd,
  input  logic [15:0] addr,
  input  logic [5:0]  count,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic        transmit,
  output logic [7:0]  tx_byte,
  input  logic        received,
  input  logic [7:0]  rx_byte,
  input  logic        is_transmitting,
  input  logic        recv_error
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, HDR_TX, GUARD, HDR_ECHO, LOAD_TX, DUMP_RX, EXEC_TX, DRAIN} state_t;
  state_t r_state, r_ret;
  logic [15:0] r_addr;
  logic [1:0] r_cmd, r_idx;
  logic [5:0] r_count, r_n;
  logic [TW-1:0] r_tmo;
  logic [7:0] w_hdr;
  logic w_tmo_run, w_tmo_hit, w_last;
  assign w_hdr = r_idx == 2'd0 ? r_addr[15:8] : r_idx == 2'd1 ? r_addr[7:0] : {r_cmd, r_count};
  assign w_tmo_run = r_state == HDR_ECHO || r_state == DUMP_RX;
  // r_tmo holds cycles elapsed since the last transmit/received, so the abort lands exactly TIMEOUT cycles later
  assign w_tmo_hit = w_tmo_run && !received && r_tmo >= TW'(TIMEOUT - 1);
  assign w_last = r_n + 6'd1 == r_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ret <= IDLE;
      r_addr <= '0;
      r_cmd <= '0;
      r_idx <= '0;
      r_count <= '0;
      r_n <= '0;
      r_tmo <= '0;
      data_ready <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= '0;
      transmit <= 1'b0;
      tx_byte <= '0;
    end else begin
      transmit <= 1'b0;
      data_ready <= 1'b0;
      rx_valid <= 1'b0;
      done <= 1'b0;
      r_tmo <= (transmit || received) ? TW'(1) : w_tmo_run ? r_tmo + 1'b1 : r_tmo;
      if (r_state != IDLE && recv_error) begin
        r_state <= IDLE; busy <= 1'b0; done <= 1'b1; err <= 2'd3;
      end else if (w_tmo_hit) begin
        r_state <= IDLE; busy <= 1'b0; done <= 1'b1; err <= 2'd2;
      end else begin
        case (r_state)
          IDLE: if (start) begin
            r_addr <= addr;
            r_cmd <= cmd;
            r_count <= count;
            r_idx <= '0;
            r_n <= '0;
            r_ret <= HDR_ECHO;
            err <= cmd == 2'd0 ? 2'd3 : 2'd0;
            done <= cmd == 2'd0;
            busy <= cmd != 2'd0;
            if (cmd != 2'd0 && !is_transmitting) begin
              transmit <= 1'b1;
              tx_byte <= addr[15:8];
              r_state <= GUARD;
            end else if (cmd != 2'd0) r_state <= HDR_TX;
          end
          HDR_TX: if (!is_transmitting) begin
            transmit <= 1'b1;
            tx_byte <= w_hdr;
            r_ret <= HDR_ECHO;
            r_state <= GUARD;
          end
          GUARD: r_state <= r_ret;
          HDR_ECHO: if (received) begin
            if (rx_byte != w_hdr) begin
              r_state <= IDLE; busy <= 1'b0; done <= 1'b1; err <= 2'd1;
            end else if (r_idx != 2'd2) begin
              r_idx <= r_idx + 2'd1;
              r_state <= HDR_TX;
            end else if (r_cmd == 2'd3) r_state <= EXEC_TX;
            else if (r_count == 6'd0) begin
              r_state <= IDLE; busy <= 1'b0; done <= 1'b1; err <= 2'd0;
            end else r_state <= r_cmd == 2'd1 ? LOAD_TX : DUMP_RX;
          end
          LOAD_TX: if (data_valid && !is_transmitting) begin
            data_ready <= 1'b1;
            transmit <= 1'b1;
            tx_byte <= data_in;
            r_n <= r_n + 6'd1;
            r_ret <= w_last ? DRAIN : LOAD_TX;
            r_state <= GUARD;
          end
          DUMP_RX: if (received) begin
            rx_data <= rx_byte;
            rx_valid <= 1'b1;
            r_n <= r_n + 6'd1;
            if (w_last) begin
              r_state <= IDLE; busy <= 1'b0; done <= 1'b1; err <= 2'd0;
            end
          end
          EXEC_TX: if (!is_transmitting) begin
            transmit <= 1'b1;
            tx_byte <= 8'h00;
            r_ret <= DRAIN;
            r_state <= GUARD;
          end
          DRAIN: if (!is_transmitting) begin
            r_state <= IDLE; busy <= 1'b0; done <= 1'b1; err <= 2'd0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_monitor_initiator.sv
// tb_monitor_initiator: directed checks of monitor_initiator against a simple uart stand-in
module tb_monitor_initiator;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, data_valid = 1'b0, received = 1'b0, recv_error = 1'b0;
  logic [1:0] cmd = '0;
  logic [15:0] addr = '0;
  logic [5:0] count = '0;
  logic [7:0] data_in = '0, rx_byte = '0;
  logic data_ready, rx_valid, busy, done, transmit, is_transmitting;
  logic [7:0] rx_data, tx_byte;
  logic [1:0] err;
  int n_chk = 0, n_err = 0;
  int tx_busy = 0, cyc = 0, tx_cyc = 0, done_cyc = 0, done_cnt = 0, ndr = 0;
  logic [1:0] last_err = '0;
  logic [7:0] tx_q[$], rx_q[$];

  monitor_initiator #(.TIMEOUT(100)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .addr(addr), .count(count),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done), .err(err),
    .transmit(transmit), .tx_byte(tx_byte), .received(received), .rx_byte(rx_byte),
    .is_transmitting(is_transmitting), .recv_error(recv_error)
  );

  always #5 clk = ~clk;
  assign is_transmitting = tx_busy != 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    tx_busy <= transmit ? 4 : (tx_busy > 0 ? tx_busy - 1 : 0);
  end

  always @(negedge clk) begin
    if (transmit) begin
      tx_q.push_back(tx_byte);
      tx_cyc <= cyc;
    end
    if (rx_valid) rx_q.push_back(rx_data);
    if (data_ready) ndr <= ndr + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      last_err <= err;
      done_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_tx(input string tag, input logic [7:0] exp);
    logic [7:0] b;
    int k = 0;
    while (tx_q.size() == 0 && k < 300) begin tick(); k++; end
    if (tx_q.size() == 0) check(tag, 32'hDEAD, 32'(exp));
    else begin
      b = tx_q.pop_front();
      check(tag, 32'(b), 32'(exp));
    end
  endtask

  task automatic expect_rx(input string tag, input logic [7:0] exp);
    logic [7:0] b;
    if (rx_q.size() == 0) check(tag, 32'hDEAD, 32'(exp));
    else begin
      b = rx_q.pop_front();
      check(tag, 32'(b), 32'(exp));
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    tick();
    received = 1'b1;
    rx_byte = b;
    tick();
    received = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [1:0] exp, input int d0);
    int k = 0;
    while (done_cnt == d0 && k < 500) begin tick(); k++; end
    if (done_cnt == d0) check(tag, 32'hDEAD, 32'(exp));
    else begin
      check(tag, 32'(last_err), 32'(exp));
      check({tag, "_busy"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic issue(input logic [1:0] c, input logic [15:0] a, input logic [5:0] n);
    cmd = c;
    addr = a;
    count = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int d0, n0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_transmit", 32'(transmit), 0);
    check("rst_tx_byte", 32'(tx_byte), 0);
    check("rst_outs", 32'({data_ready, rx_valid, rx_data}), 0);
    rst_n = 1'b1;
    tick();

    d0 = done_cnt;
    issue(2'd2, 16'h1234, 6'd2);
    check("dump_busy_n1", 32'(busy), 1);
    check("dump_tx_n1", 32'(transmit), 1);
    expect_tx("dump_h0", 8'h12); send_rx(8'h12);
    expect_tx("dump_h1", 8'h34); send_rx(8'h34);
    expect_tx("dump_h2", 8'h82); send_rx(8'h82);
    send_rx(8'h02);
    send_rx(8'h01);
    wait_done("dump_err", 2'd0, d0);
    expect_rx("dump_rx0", 8'h02);
    expect_rx("dump_rx1", 8'h01);

    d0 = done_cnt;
    n0 = ndr;
    data_in = 8'hA5;
    data_valid = 1'b1;
    issue(2'd1, 16'h00FF, 6'd2);
    expect_tx("load_h0", 8'h00); send_rx(8'h00);
    expect_tx("load_h1", 8'hFF); send_rx(8'hFF);
    expect_tx("load_h2", 8'h42); send_rx(8'h42);
    expect_tx("load_d0", 8'hA5);
    data_in = 8'h5A;
    expect_tx("load_d1", 8'h5A);
    data_valid = 1'b0;
    wait_done("load_err", 2'd0, d0);
    check("load_ready_cnt", 32'(ndr - n0), 32'd2);

    d0 = done_cnt;
    issue(2'd2, 16'h1234, 6'd1);
    expect_tx("echo_h0", 8'h12);
    send_rx(8'h13);
    wait_done("echo_err", 2'd1, d0);
    repeat (20) tick();
    check("echo_no_tx", 32'(tx_q.size()), 0);

    d0 = done_cnt;
    issue(2'd3, 16'hBEEF, 6'd0);
    expect_tx("tmo_h0", 8'hBE);
    wait_done("tmo_err", 2'd2, d0);
    check("tmo_cycles", 32'(done_cyc - tx_cyc), 32'd100);

    d0 = done_cnt;
    issue(2'd0, 16'h5555, 6'd4);
    check("inv_done", 32'(done), 1);
    check("inv_err", 32'(err), 3);
    check("inv_busy", 32'(busy), 0);
    repeat (5) tick();
    check("inv_no_tx", 32'(tx_q.size()), 0);

    d0 = done_cnt;
    issue(2'd2, 16'h0102, 6'd3);
    expect_tx("rxe_h0", 8'h01); send_rx(8'h01);
    expect_tx("rxe_h1", 8'h02); send_rx(8'h02);
    expect_tx("rxe_h2", 8'h83); send_rx(8'h83);
    send_rx(8'hAA);
    tick();
    recv_error = 1'b1;
    tick();
    recv_error = 1'b0;
    wait_done("rxe_err", 2'd3, d0);
    expect_rx("rxe_rx0", 8'hAA);

    issue(2'd1, 16'h4000, 6'd2);
    expect_tx("ar_h0", 8'h40); send_rx(8'h40);
    expect_tx("ar_h1", 8'h00); send_rx(8'h00);
    expect_tx("ar_h2", 8'h42); send_rx(8'h42);
    repeat (3) tick();
    check("ar_stall_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("ar_busy", 32'(busy), 0);
    check("ar_err", 32'(err), 0);
    check("ar_tx_byte", 32'(tx_byte), 0);
    check("ar_pulses", 32'({done, transmit, data_ready, rx_valid}), 0);
    tick();
    rst_n = 1'b1;
    tick();
    tx_q.delete();
    rx_q.delete();
    d0 = done_cnt;
    issue(2'd2, 16'h0001, 6'd1);
    expect_tx("post_h0", 8'h00); send_rx(8'h00);
    expect_tx("post_h1", 8'h01); send_rx(8'h01);
    expect_tx("post_h2", 8'h81); send_rx(8'h81);
    send_rx(8'h77);
    wait_done("post_err", 2'd0, d0);
    expect_rx("post_rx0", 8'h77);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/monitor_initiator.md
# monitor_initiator

Host-side initiator for the 3-byte serial monitor protocol (address high, address low, length/command), sitting between a local command source and a `uart` instance (9600 baud, 12 MHz system clock). On a start request it sends the header one byte at a time, checks each echoed byte from the remote monitor, then runs the payload phase: LOAD bytes out, DUMP bytes in, or one EXEC trigger byte. It reports completion and an error code, and includes a receive timeout.

## Interface

Parameters:
- `TIMEOUT`, 50000: clock cycles to wait for any expected received byte before aborting. The counter is `$clog2(TIMEOUT+1)` bits wide.

Ports:
- `clk` input 1: system clock. Single clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: command request, sampled only while `busy`=0.
- `cmd` input 2: 1=LOAD, 2=DUMP, 3=EXEC, 0=invalid.
- `addr` input 16: target address.
- `count` input 6: payload byte count for LOAD/DUMP. Ignored for EXEC.
- `data_in` input 8: LOAD payload byte.
- `data_valid` input 1: `data_in` is valid.
- `data_ready` output 1: one-cycle pulse when `data_in` is consumed.
- `rx_data` output 8: DUMP byte received.
- `rx_valid` output 1: one-cycle pulse qualifying `rx_data`. No backpressure.
- `busy` output 1: a command is in progress.
- `done` output 1: one-cycle pulse at command end.
- `err` output 2: result, valid with `done` and held until the next `start`. 0=ok, 1=echo mismatch, 2=timeout, 3=protocol (`recv_error` seen or invalid `cmd`).
- `transmit` output 1: to `uart.transmit`.
- `tx_byte` output 8: to `uart.tx_byte`.
- `received` input 1: from `uart.received`.
- `rx_byte` input 8: from `uart.rx_byte`.
- `is_transmitting` input 1: from `uart.is_transmitting`.
- `recv_error` input 1: from `uart.recv_error`.

## Operation

- Reset values: all outputs 0, `err`=0, state IDLE.
- The command is latched on `start` in IDLE. The header is {addr[15:8], addr[7:0], {cmd, count}}.
- States:
  - IDLE: on `start` with `cmd`≠0, go to HDR_TX with header index 0. On `start` with `cmd`=0, pulse `done` with `err`=3 and do not assert `busy`.
  - HDR_TX: when `is_transmitting`=0, drive `tx_byte`=header[idx], pulse `transmit`, go to GUARD, then HDR_ECHO.
  - HDR_ECHO: wait for `received`.
    - `rx_byte`≠header[idx]: finish with `err`=1.
    - idx<2: increment idx, go to HDR_TX.
    - idx=2: go to the payload state selected by `cmd`.
  - LOAD_TX: repeat `count` times:
    - wait for `data_valid` and `is_transmitting`=0;
    - pulse `data_ready` and `transmit` in the same cycle with `tx_byte`=`data_in`;
    - GUARD cycle.
    - After the last byte, wait for `is_transmitting`=0, then finish with ok.
  - DUMP_RX: on each `received`, copy `rx_byte` to `rx_data` and pulse `rx_valid`. Finish with ok after `count` bytes.
  - EXEC_TX: send one 0x00 byte, wait for `is_transmitting`=0, then finish with ok.
  - GUARD: one idle cycle after every `transmit`, so the UART can raise `is_transmitting`.
  - FINISH: `done` pulses, `busy` drops, return to IDLE.
- `count`=0 for LOAD/DUMP: skip the payload phase and finish ok right after the third echo.
- Timeout counter:
  - reloads on every `transmit` pulse and every `received`;
  - runs only in HDR_ECHO and DUMP_RX;
  - reaching `TIMEOUT` finishes with `err`=2.
- `recv_error`=1 in any non-IDLE state finishes with `err`=3. It takes priority over `received` in the same cycle.
- `received` in IDLE, LOAD_TX or EXEC_TX is ignored.
- Deasserting `rst_n` mid-command aborts immediately to the reset values. No `done` pulse is produced.

## Timing

- `start` at cycle N gives `busy`=1 and the first `transmit` at N+1 at the earliest (requires `is_transmitting`=0).
- `transmit`, `data_ready`, `rx_valid` and `done` are each exactly one cycle wide.
- At least one GUARD cycle separates consecutive `transmit` pulses.
- `rx_valid` appears the cycle after `received`.
- `done` appears the cycle after the terminating event (last echo, last byte, timeout, error). `busy` falls in the same cycle `done` rises.
- `start` while `busy`=1 is ignored.

## Test plan

- DUMP, `addr`=0x1234, `count`=2; model echoes 0x12, 0x34, 0x82, then sends 0x02, 0x01 -> three `transmit` pulses with those bytes; `rx_valid` with 0x02 then 0x01; `done` with `err`=0.
- LOAD, `addr`=0x00FF, `count`=2, `data_in` 0xA5 then 0x5A -> header 0x00, 0xFF, 0x42; two `data_ready` pulses; 0xA5 and 0x5A transmitted; `err`=0.
- DUMP; model echoes 0x13 instead of 0x12 -> `done` with `err`=1 after the first echo; no second `transmit`.
- EXEC with `TIMEOUT`=100; model sends no echo -> `done` with `err`=2 exactly 100 cycles after the first `transmit`.
- `cmd`=0 -> `done` with `err`=3 next cycle, `busy` stays 0, no `transmit`. Separately, `recv_error` during DUMP_RX -> `err`=3.
- Assert `rst_n`=0 during LOAD_TX -> all outputs 0 immediately; a new DUMP after release completes with `err`=0.
